// File: rtl/mem_access_arbiter_pkg.sv
// mem_access_arbiter_pkg: shared widths and tag-table entry type for the memory access arbiter.
package MemAccessArbiterTypes;
    localparam int ARB_MAX_PORTS = 8;
    localparam int ARB_MAX_SERIAL_WIDTH = 16;
    localparam int MEMORY_ENTRY_DATA_WIDTH = 128;
    localparam int MEM_ACCESS_SERIAL_WIDTH = 5;
    typedef logic [MEMORY_ENTRY_DATA_WIDTH-1:0] MemoryEntryDataPath;
    typedef logic [MEM_ACCESS_SERIAL_WIDTH-1:0] MemAccessSerial;
    typedef logic [$clog2(ARB_MAX_PORTS)-1:0] ArbPortIndexPath;
    typedef logic [ARB_MAX_SERIAL_WIDTH-1:0] ArbSerialPath;
    typedef struct packed {
        logic            valid;
        ArbSerialPath    serial;
        ArbPortIndexPath port;
    } ArbTagEntry;
endpackage

// File: rtl/mem_read_tag_table.sv
// mem_read_tag_table: CAM of in-flight read serials; allocates the lowest free entry and
// frees the lowest matching entry when read data returns.
module mem_read_tag_table
    import MemAccessArbiterTypes::*;
#(
    parameter int DEPTH = 8,
    parameter int SERIAL_WIDTH = MEM_ACCESS_SERIAL_WIDTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    negResetIn,
    input  logic                    alloc_i,
    input  logic [SERIAL_WIDTH-1:0] alloc_serial_i,
    input  ArbPortIndexPath         alloc_port_i,
    input  logic                    lookup_i,
    input  logic [SERIAL_WIDTH-1:0] lookup_serial_i,
    output logic                    hit_o,
    output ArbPortIndexPath         hit_port_o,
    output logic                    full_o,
    output logic [CW-1:0]           count_o
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    ArbTagEntry entry_q [DEPTH];
    logic [DEPTH-1:0] valid, match;
    logic [IW-1:0] free_idx, hit_idx;

    // Descending scan so the lowest index wins for both free slot and match.
    always_comb begin
        valid = '0;
        match = '0;
        free_idx = '0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            valid[i] = entry_q[i].valid;
            match[i] = entry_q[i].valid && entry_q[i].serial == ArbSerialPath'(lookup_serial_i);
            if (!valid[i]) free_idx = IW'(i);
            if (match[i]) hit_idx = IW'(i);
        end
    end

    assign hit_o = lookup_i && |match;
    assign hit_port_o = entry_q[hit_idx].port;
    assign full_o = &valid;
    assign count_o = CW'($countones(valid));

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            if (alloc_i) entry_q[free_idx] <= '{valid: 1'b1, serial: ArbSerialPath'(alloc_serial_i), port: alloc_port_i};
            if (hit_o) entry_q[hit_idx].valid <= 1'b0;
        end
    end

    a_unique_serial: assert property (@(posedge clk) disable iff (!negResetIn) lookup_i |-> $onehot0(match));
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin arbiter of NUM_PORTS requesters onto one memory port,
// with an exclusive-owner mode and per-serial routing of returned reads.
module mem_access_arbiter
    import MemAccessArbiterTypes::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = MEMORY_ENTRY_DATA_WIDTH,
    parameter int SERIAL_WIDTH = MEM_ACCESS_SERIAL_WIDTH,
    parameter int OUTSTANDING_DEPTH = 8,
    parameter int EXCLUSIVE_PORT = 0,
    localparam int CW = $clog2(OUTSTANDING_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            negResetIn,
    input  logic                            exclusiveMode,
    input  logic [NUM_PORTS-1:0]            reqRE,
    input  logic [NUM_PORTS-1:0]            reqWE,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] reqAddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] reqWriteData,
    output logic [NUM_PORTS-1:0]            reqGrant,
    output logic [SERIAL_WIDTH-1:0]         reqReadSerial,
    output logic [ADDR_WIDTH-1:0]           memAccessAddr,
    output logic [DATA_WIDTH-1:0]           memAccessWriteData,
    output logic                            memAccessRE,
    output logic                            memAccessWE,
    input  logic                            memAccessReadBusy,
    input  logic                            memAccessWriteBusy,
    input  logic [SERIAL_WIDTH-1:0]         nextMemReadSerial,
    input  logic                            memReadDataReady,
    input  logic [DATA_WIDTH-1:0]           memReadData,
    input  logic [SERIAL_WIDTH-1:0]         memReadSerial,
    output logic [NUM_PORTS-1:0]            rspValid,
    output logic [DATA_WIDTH-1:0]           rspData,
    output logic [SERIAL_WIDTH-1:0]         rspSerial,
    output logic [CW-1:0]                   outstandingCount,
    output logic                            errUnknownSerial
);
    ArbPortIndexPath rr_ptr_q, rr_ptr_d, winner, rsp_port;
    logic found, full, hit, err_q;
    logic [NUM_PORTS-1:0] elig, rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [SERIAL_WIDTH-1:0] rsp_serial_q;

    // A port asserting both RE and WE is a write only.
    always_comb begin
        elig = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            elig[p] = (!exclusiveMode || p == EXCLUSIVE_PORT) &&
                      (reqWE[p] ? !memAccessWriteBusy : reqRE[p] && !memAccessReadBusy && !full);
    end

    // Winner is the eligible port with the smallest distance from rr_ptr_q.
    always_comb begin
        int d, best;
        best = NUM_PORTS;
        d = 0;
        winner = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            d = p >= int'(rr_ptr_q) ? p - int'(rr_ptr_q) : p + NUM_PORTS - int'(rr_ptr_q);
            if (elig[p] && d < best) begin
                best = d;
                winner = ArbPortIndexPath'(p);
            end
        end
        found = best < NUM_PORTS;
    end

    assign reqGrant = found ? NUM_PORTS'(1) << winner : '0;
    assign memAccessWE = |(reqGrant & reqWE);
    assign memAccessRE = |(reqGrant & reqRE & ~reqWE);
    assign reqReadSerial = nextMemReadSerial;
    assign rr_ptr_d = winner == ArbPortIndexPath'(NUM_PORTS - 1) ? '0 : winner + 1'b1;

    always_comb begin
        memAccessAddr = '0;
        memAccessWriteData = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (reqGrant[p]) begin
                memAccessAddr = reqAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
                memAccessWriteData = reqWriteData[p*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    mem_read_tag_table #(.DEPTH(OUTSTANDING_DEPTH), .SERIAL_WIDTH(SERIAL_WIDTH)) u_tag_table (
        .clk(clk),
        .negResetIn(negResetIn),
        .alloc_i(memAccessRE),
        .alloc_serial_i(nextMemReadSerial),
        .alloc_port_i(winner),
        .lookup_i(memReadDataReady),
        .lookup_serial_i(memReadSerial),
        .hit_o(hit),
        .hit_port_o(rsp_port),
        .full_o(full),
        .count_o(outstandingCount)
    );

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            rr_ptr_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q <= '0;
            rsp_serial_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (found) rr_ptr_q <= rr_ptr_d;
            rsp_valid_q <= hit ? NUM_PORTS'(1) << rsp_port : '0;
            if (hit) begin
                rsp_data_q <= memReadData;
                rsp_serial_q <= memReadSerial;
            end
            err_q <= err_q || (memReadDataReady && !hit);
        end
    end

    assign rspValid = rsp_valid_q;
    assign rspData = rsp_data_q;
    assign rspSerial = rsp_serial_q;
    assign errUnknownSerial = err_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed scoreboard bench for mem_access_arbiter (3 ports, 8 tags).
module tb_mem_access_arbiter;
    localparam int NP = 3, AW = 32, DW = 128, SW = 5;

    typedef struct { logic [NP-1:0] oh; logic [SW-1:0] s; } ent_t;
    typedef struct { logic [NP-1:0] oh; logic [SW-1:0] s; logic [DW-1:0] d; } rsp_t;

    logic clk = 0, negResetIn = 1, exclusiveMode = 0;
    logic [NP-1:0] reqRE = 0, reqWE = 0, reqGrant, rspValid;
    logic [NP*AW-1:0] reqAddr;
    logic [NP*DW-1:0] reqWriteData;
    logic [SW-1:0] reqReadSerial, nextMemReadSerial = 3, memReadSerial = 0, rspSerial;
    logic [AW-1:0] memAccessAddr;
    logic [DW-1:0] memAccessWriteData, memReadData = 0, rspData;
    logic memAccessRE, memAccessWE, memAccessReadBusy = 0, memAccessWriteBusy = 0;
    logic memReadDataReady = 0, errUnknownSerial;
    logic [3:0] outstandingCount;

    int checks = 0, errors = 0;
    logic err_exp = 0;
    ent_t outst[$];
    rsp_t exp_rsp[$];

    mem_access_arbiter dut (
        .clk(clk), .negResetIn(negResetIn), .exclusiveMode(exclusiveMode),
        .reqRE(reqRE), .reqWE(reqWE), .reqAddr(reqAddr), .reqWriteData(reqWriteData),
        .reqGrant(reqGrant), .reqReadSerial(reqReadSerial),
        .memAccessAddr(memAccessAddr), .memAccessWriteData(memAccessWriteData),
        .memAccessRE(memAccessRE), .memAccessWE(memAccessWE),
        .memAccessReadBusy(memAccessReadBusy), .memAccessWriteBusy(memAccessWriteBusy),
        .nextMemReadSerial(nextMemReadSerial), .memReadDataReady(memReadDataReady),
        .memReadData(memReadData), .memReadSerial(memReadSerial),
        .rspValid(rspValid), .rspData(rspData), .rspSerial(rspSerial),
        .outstandingCount(outstandingCount), .errUnknownSerial(errUnknownSerial)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata(input logic [SW-1:0] s);
        return {4{27'h5A5A5A5, s}};
    endfunction

    // Present a read return; the expected routing comes from the bench's own outstanding list.
    task automatic drive_ret(input logic [SW-1:0] s);
        rsp_t r;
        int k;
        k = -1;
        r.oh = '0;
        r.s = s;
        r.d = rdata(s);
        for (int i = 0; i < outst.size(); i++)
            if (k < 0 && outst[i].s == s) k = i;
        if (k >= 0) begin
            r.oh = outst[k].oh;
            outst.delete(k);
        end else err_exp = 1;
        memReadDataReady = 1;
        memReadSerial = s;
        memReadData = r.d;
        exp_rsp.push_back(r);
    endtask

    // One clock: check the combinational grant/mux, advance, check registered outputs.
    task automatic cyc(input logic [NP-1:0] eg);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic rd, had;
        rsp_t r;
        ea = '0;
        ed = '0;
        #1;
        for (int p = 0; p < NP; p++)
            if (eg[p]) begin
                ea = reqAddr[p*AW +: AW];
                ed = reqWriteData[p*DW +: DW];
            end
        rd = |(eg & reqRE & ~reqWE);
        chk("grant", reqGrant, eg);
        chk("mem_addr", memAccessAddr, ea);
        chk("mem_wdata", memAccessWriteData, ed);
        chk("mem_re", memAccessRE, rd);
        chk("mem_we", memAccessWE, |(eg & reqWE));
        if (rd) outst.push_back('{eg, nextMemReadSerial});
        had = memReadDataReady;
        @(posedge clk);
        #1;
        if (rd) nextMemReadSerial++;
        memReadDataReady = 0;
        if (had && exp_rsp.size() > 0) begin
            r = exp_rsp.pop_front();
            chk("rsp_valid", rspValid, r.oh);
            if (r.oh != 0) begin
                chk("rsp_data", rspData, r.d);
                chk("rsp_serial", rspSerial, r.s);
            end
        end else chk("rsp_valid_idle", rspValid, 0);
        chk("count", outstandingCount, outst.size());
        chk("err_unknown", errUnknownSerial, err_exp);
    endtask

    task automatic do_reset();
        negResetIn = 0;
        #2;
        chk("rst_rsp_valid", rspValid, 0);
        chk("rst_rsp_data", rspData, 0);
        chk("rst_rsp_serial", rspSerial, 0);
        chk("rst_count", outstandingCount, 0);
        chk("rst_err", errUnknownSerial, 0);
        outst.delete();
        exp_rsp.delete();
        err_exp = 0;
        negResetIn = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            reqAddr[p*AW +: AW] = 32'h1000_0000 + 32'(p);
            reqWriteData[p*DW +: DW] = {4{32'hD000_0000 + 32'(p)}};
        end
        @(posedge clk);
        #1;
        do_reset();
        cyc(3'b000);

        // Round-robin reads from all ports, serials 3..6.
        reqRE = 3'b111;
        cyc(3'b001);
        cyc(3'b010);
        cyc(3'b100);
        cyc(3'b001);
        reqRE = 3'b000;

        // Exclusive mode locks out port 1 until dropped.
        exclusiveMode = 1;
        reqWE = 3'b011;
        cyc(3'b001);
        cyc(3'b001);
        exclusiveMode = 0;
        cyc(3'b010);
        cyc(3'b001);
        reqWE = 3'b000;
        drive_ret(3); cyc(3'b000);
        drive_ret(6); cyc(3'b000);
        drive_ret(4); cyc(3'b000);
        drive_ret(5); cyc(3'b000);

        // Out-of-order returns route to the issuing port.
        reqRE = 3'b010; cyc(3'b010);
        reqRE = 3'b100; cyc(3'b100);
        reqRE = 3'b000;
        drive_ret(8); cyc(3'b000);
        drive_ret(7); cyc(3'b000);

        // Fill the table; a read stays blocked on the freeing cycle.
        reqRE = 3'b111;
        for (int i = 0; i < 8; i++) cyc(3'(1 << (i % 3)));
        cyc(3'b000);
        drive_ret(9); cyc(3'b000);
        cyc(3'b100);
        reqRE = 3'b000;
        for (int s = 10; s <= 17; s++) begin
            drive_ret(5'(s));
            cyc(3'b000);
        end

        // Unknown serial sets a sticky error cleared only by reset.
        drive_ret(31); cyc(3'b000);
        cyc(3'b000);
        do_reset();

        // RE+WE behaves as write; blocked by write busy only.
        reqRE = 3'b010;
        reqWE = 3'b010;
        memAccessWriteBusy = 1;
        cyc(3'b000);
        memAccessWriteBusy = 0;
        cyc(3'b010);
        reqWE = 3'b000;
        reqRE = 3'b001;
        cyc(3'b001);
        cyc(3'b001);
        cyc(3'b001);
        reqRE = 3'b000;
        drive_ret(18); cyc(3'b000);
        do_reset();
        drive_ret(19); cyc(3'b000);
        cyc(3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
